debounce_pulse: RTL

Input conditioning stage that sits directly upstream of the 3-bit counter FSM. It takes a raw, asynchronous, bouncing push-button signal and synchronises and debounces it. It emits a single-cycle `tick_out` pulse per accepted press, which drives the counter's advance/enable. It also exports the debounced button level for LEDs or other consumers.

---
 rtl/debounce_pulse_if.sv | 19 +
 rtl/debounce_pulse.sv | 98 +++++++++
 2 files changed

// File: rtl/debounce_pulse_if.sv
// Button-side signal bundle for the debounce stage: raw button in,
// accepted-press pulse and debounced level out.
interface debounce_pulse_if;
    logic btn_in;
    logic tick_out;
    logic level_out;

    modport master (
        output btn_in,
        input  tick_out,
        input  level_out
    );

    modport slave (
        input  btn_in,
        output tick_out,
        output level_out
    );
endinterface

// File: rtl/debounce_pulse.sv
// Synchronises and debounces a raw push-button, exporting the stable level
// and a one-cycle tick per accepted press (never on release).
module debounce_pulse #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    debounce_pulse_if.slave  bus
);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tick_q,  tick_d;
    logic             level_q, level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    // A reversal of the sample always wins over counter completion, so a level
    // is only accepted if it still holds on the final counted cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (s2_q) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s2_q) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (s2_q) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_LOW;
        endcase
        level_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
    end

    assign bus.tick_out  = tick_q;
    assign bus.level_out = level_q;

endmodule
